wr_arbiter: RTL and testbench
=============================

WR_ARBITER -- requirements
Module: wr_arbiter

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256: cache line width in bits, a multiple of 32.
REQ-002 SHALL have parameter AWID, default 2: value driven on awid and wid.
REQ-003 SHALL have parameter BUS_WIDTH, default 4: ID width of the axi3_wr_if bus.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port line_req, input, 1: write-buffer line write request; held until line_done.
REQ-007 SHALL have port line_addr, input, 32: line physical address.
REQ-008 SHALL have port line_data, input, LINE_WIDTH: line payload, word 0 in bits [31:0].
REQ-009 SHALL have port line_done, output, 1: one-cycle completion pulse for the line port.
REQ-010 SHALL have port word_req, input, 1: uncached single-word write request; held until word_done.
REQ-011 SHALL have ports word_addr (input, 32), word_data (input, 32) and word_be (input, 4): uncached address, data and byte enables.
REQ-012 SHALL have port word_done, output, 1: one-cycle completion pulse for the word port.
REQ-013 SHALL have port busy, output, 1: a transaction is in flight.
REQ-014 SHALL have port axi, axi3_wr_if master modport: shared AXI3 write channel.

Function
REQ-015 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE, with at most one outstanding transaction.
REQ-016 SHALL, in IDLE, grant one pending requester and latch its address, data and byte enables, then enter ADDR on the next edge; requester inputs are don't-care after grant.
REQ-017 SHALL, in ADDR, assert awvalid until awready, then enter DATA.
REQ-018 SHALL drive the AW fields as follows: awsize 3'b010, awburst 2'b01 (INCR), awid AWID.
REQ-019 SHALL, for a line, drive awlen = LINE_WIDTH/32-1 and awaddr = line_addr with the low log2(LINE_WIDTH/8) bits forced to zero.
REQ-020 SHALL, for a word, drive awlen 0 and awaddr = word_addr.
REQ-021 SHALL, in DATA, assert wvalid, driving the latched word selected by a beat counter (lowest word first) and incrementing the counter on wvalid&wready.
REQ-022 SHALL assert wlast on the final beat only and enter RESP after the final beat handshakes.
REQ-023 SHALL drive wstrb 4'hF for a line and word_be for a word; a word with word_be 0 is still issued as a single beat.
REQ-024 SHALL, in RESP, hold bready=1; on bvalid it SHALL pulse the granted port's done in that same cycle (combinational) and return to IDLE.
REQ-025 SHALL ignore bresp; an error response is treated as completion.
REQ-026 SHALL give a minimum line transaction of LINE_WIDTH/32+3 cycles (11 at default) from grant to done, and a minimum word transaction of 4 cycles.
REQ-027 SHALL hold awvalid, wvalid and the done outputs low outside their states; busy = (state != IDLE).
REQ-028 SHALL re-evaluate a request that drops before grant; no grant is issued for it.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-burst, force IDLE, clear the beat counter and latches, deassert awvalid, wvalid, bready, line_done, word_done and busy, and set the arbitration pointer to favour the word port.
REQ-030 SHALL drop any in-flight transaction on reset without completion; the requesters reissue it.

Configuration
REQ-031 SHALL support macro WR_ARBITER_RR_EN: when defined, simultaneous requests go to the port not granted last (round-robin pointer updated on each grant).
REQ-032 SHALL, when WR_ARBITER_RR_EN is undefined, use fixed priority in which word_req always wins over line_req.

Verification
REQ-033 Single line, line_addr 32'h1000_0014, data words 0..7 = 32'h0..32'h7, ready always high -> awaddr 32'h1000_0000, awlen 7, 8 beats 0..7, wlast on beat 7, line_done at cycle 11.
REQ-034 Single word, word_addr 32'hBFD0_0004, word_data 32'hDEAD_BEEF, word_be 4'b0011 -> awlen 0, wstrb 4'b0011, wlast on the first beat, word_done at cycle 4.
REQ-035 line_req and word_req rise in the same cycle, repeated 4 times -> with RR_EN the grants are word, line, word, line; without it all 4 words complete before any line.
REQ-036 wready toggled 1/0 each cycle during a line burst -> beat order 0..7 is preserved, wdata is stable while wvalid&!wready, and the burst takes 16 DATA cycles.
REQ-037 rst_n asserted on beat 3 of a line burst -> wvalid and busy go low immediately, no line_done is issued, and after release a fresh line request starts at beat 0.
REQ-038 bvalid delayed 5 cycles and bresp 2'b10 -> bready is held, line_done pulses exactly once, and the next grant occurs the cycle after.

Source files
------------

// File: rtl/axi3_wr_if.sv
// ---------------------------------------------------------------------------
// axi3_wr_if -- AXI3 write-only channel bundle (AW, W, B).
//
// Parameters:
//   BUS_WIDTH : width of the awid / wid / bid fields.
//
// Modports:
//   master : drives AW/W payload and valids plus bready; samples awready,
//            wready and the B channel.
//   slave  : the mirror image, used by memory models and interconnect.
// ---------------------------------------------------------------------------
interface axi3_wr_if #(
  parameter int BUS_WIDTH = 4
);

  // Write address channel
  logic [BUS_WIDTH-1:0] awid;
  logic [31:0]          awaddr;
  logic [3:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic                 awvalid;
  logic                 awready;

  // Write data channel
  logic [BUS_WIDTH-1:0] wid;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;

  // Write response channel
  logic [BUS_WIDTH-1:0] bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/wr_arbiter.sv
// ---------------------------------------------------------------------------
// wr_arbiter -- shares one AXI3 write channel between a cache-line write
// port (write buffer) and an uncached single-word write port. One
// transaction is in flight at a time: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//
// Parameters:
//   LINE_WIDTH : cache line width in bits (multiple of 32, at most 512 so
//                the burst fits the 4-bit AXI3 awlen).
//   AWID       : constant ID driven on awid and wid.
//   BUS_WIDTH  : ID field width of the AXI bus.
//
// Ports:
//   clk, rst_n            : clock (posedge) and asynchronous active-low reset.
//   line_req / line_addr / line_data / line_done :
//                           line write request (held until done), line
//                           address, payload (word 0 in bits [31:0]) and a
//                           one-cycle completion pulse.
//   word_req / word_addr / word_data / word_be / word_done :
//                           uncached single-word write request, payload,
//                           byte enables and one-cycle completion pulse.
//   busy                  : a transaction is in flight.
//   axi                   : AXI3 write channel, master side.
//
// Configuration macro:
//   WR_ARBITER_RR_EN : when defined, simultaneous requests alternate between
//                      the ports (round robin). When undefined the word port
//                      always wins over the line port.
// ---------------------------------------------------------------------------
module wr_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int AWID       = 2,
  parameter int BUS_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  line_req,
  input  logic [31:0]           line_addr,
  input  logic [LINE_WIDTH-1:0] line_data,
  output logic                  line_done,

  input  logic                  word_req,
  input  logic [31:0]           word_addr,
  input  logic [31:0]           word_data,
  input  logic [3:0]            word_be,
  output logic                  word_done,

  output logic                  busy,

  axi3_wr_if.master             axi
);

  localparam int BEATS = LINE_WIDTH / 32;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Line bursts start on a line boundary: clear the byte offset bits.
  localparam logic [31:0]      LINE_MASK = ~32'(LINE_WIDTH / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_is_word;   // granted port: 1 = word, 0 = line
  logic [31:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_data;
  logic [3:0]            r_be;
  logic [CNT_W-1:0]      r_beat;

  logic                  w_grant;
  logic                  w_grant_word;
  logic                  w_last;
  logic                  w_awvalid;
  logic                  w_wvalid;
  logic                  w_bready;
  logic [CNT_W+4:0]      w_bit_base;  // bit offset of the current beat
  logic                  w_unused;

`ifdef WR_ARBITER_RR_EN
  logic                  r_last_word; // last grant went to the word port
`endif

  // A word transaction is always a single beat.
  assign w_last     = r_is_word || (r_beat == LAST_BEAT);
  assign w_bit_base = {r_beat, 5'd0};

  // -------------------------------------------------------------------------
  // Next state, grant and channel controls
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_word = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    line_done    = 1'b0;
    word_done    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A request that drops before this cycle simply is not seen here.
        if (line_req || word_req) begin
          w_grant = 1'b1;
`ifdef WR_ARBITER_RR_EN
          w_grant_word = word_req && (!line_req || !r_last_word);
`else
          w_grant_word = word_req;
`endif
          w_next = ST_ADDR;
        end
      end

      ST_ADDR: begin
        w_awvalid = 1'b1;
        if (axi.awready) w_next = ST_DATA;
      end

      ST_DATA: begin
        w_wvalid = 1'b1;
        if (axi.wready && w_last) w_next = ST_RESP;
      end

      ST_RESP: begin
        w_bready = 1'b1;
        // bresp is ignored: an error response still completes the request.
        if (axi.bvalid) begin
          line_done = !r_is_word;
          word_done = r_is_word;
          w_next    = ST_IDLE;
        end
      end

      default: w_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // Request latches and beat counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the wide payload latch is reset too, so an aborted burst never
    // leaves stale data that could be mistaken for a later request's.
    if (!rst_n) begin
      r_is_word <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_be      <= '0;
      r_beat    <= '0;
    end else if (w_grant) begin
      r_is_word <= w_grant_word;
      r_beat    <= '0;
      if (w_grant_word) begin
        r_addr <= word_addr;
        r_data <= LINE_WIDTH'(word_data);
        r_be   <= word_be;
      end else begin
        r_addr <= line_addr & LINE_MASK;
        r_data <= line_data;
        r_be   <= 4'hF;
      end
    end else if (w_wvalid && axi.wready && !w_last) begin
      r_beat <= r_beat + 1'b1;
    end
  end

`ifdef WR_ARBITER_RR_EN
  // Reset value 0 means "line went last", so the word port wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_word <= 1'b0;
    end else if (w_grant) begin
      r_last_word <= w_grant_word;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Bus outputs
  // -------------------------------------------------------------------------
  assign axi.awvalid = w_awvalid;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = r_is_word ? 4'd0 : 4'(BEATS - 1);
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awid    = BUS_WIDTH'(AWID);

  assign axi.wvalid  = w_wvalid;
  assign axi.wdata   = r_data[w_bit_base +: 32];
  assign axi.wstrb   = r_be;
  assign axi.wlast   = w_wvalid && w_last;
  assign axi.wid     = BUS_WIDTH'(AWID);

  assign axi.bready  = w_bready;

  assign busy        = (r_state != ST_IDLE);

  // The B channel ID and response code carry nothing this block acts on.
  assign w_unused    = ^{axi.bid, axi.bresp};

endmodule

// File: tb/tb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wr_arbiter -- directed self-checking bench for wr_arbiter.
// A single negedge process plays the AXI slave (awready always high,
// optional wready toggling, configurable B delay and response) and logs
// every handshake; the test tasks drive requesters one time unit after
// posedge and compare the logs with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_wr_arbiter;

  localparam int LW    = 256;
  localparam int BEATS = LW / 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;

  logic          line_req = 1'b0;
  logic [31:0]   line_addr = '0;
  logic [LW-1:0] line_data = '0;
  logic          line_done;

  logic          word_req = 1'b0;
  logic [31:0]   word_addr = '0;
  logic [31:0]   word_data = '0;
  logic [3:0]    word_be = '0;
  logic          word_done;
  logic          busy;

  axi3_wr_if #(.BUS_WIDTH(4)) axi_bus ();

  wr_arbiter #(
    .LINE_WIDTH(LW),
    .AWID      (2),
    .BUS_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_req (line_req),
    .line_addr(line_addr),
    .line_data(line_data),
    .line_done(line_done),
    .word_req (word_req),
    .word_addr(word_addr),
    .word_data(word_data),
    .word_be  (word_be),
    .word_done(word_done),
    .busy     (busy),
    .axi      (axi_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave configuration
  bit         cfg_toggle = 1'b0;
  int         cfg_bdelay = 0;
  logic [1:0] cfg_bresp  = 2'b00;

  // Monitor logs
  int          cyc = 0;
  int          b_cnt = -1;
  logic [31:0] aw_addr_q[$];
  logic [3:0]  aw_len_q[$];
  int          aw_cyc_q[$];
  logic [31:0] w_data_q[$];
  logic [3:0]  w_strb_q[$];
  bit          w_last_q[$];
  logic [2:0]  aw_size_seen;
  logic [1:0]  aw_burst_seen;
  logic [3:0]  aw_id_seen;
  logic [3:0]  w_id_seen;
  int          line_done_cnt = 0;
  int          word_done_cnt = 0;
  int          line_done_cyc = 0;
  int          word_done_cyc = 0;
  int          data_cycles = 0;
  int          bwait_cycles = 0;
  int          unstable = 0;
  bit          held = 1'b0;
  logic [31:0] held_wdata = '0;

  // AXI slave model and handshake monitor
  initial begin
    axi_bus.awready = 1'b1;
    axi_bus.wready  = 1'b1;
    axi_bus.bvalid  = 1'b0;
    axi_bus.bresp   = 2'b00;
    axi_bus.bid     = 4'd2;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        axi_bus.bvalid = 1'b0;
        axi_bus.wready = 1'b1;
        b_cnt = -1;
        held  = 1'b0;
        continue;
      end
      // Drive slave outputs for the coming posedge
      if (axi_bus.bvalid) axi_bus.bvalid = 1'b0;
      if (b_cnt == 0) begin
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = cfg_bresp;
        b_cnt = -1;
      end else if (b_cnt > 0) begin
        b_cnt--;
      end
      if (cfg_toggle) axi_bus.wready = axi_bus.wvalid ? ~axi_bus.wready : 1'b1;
      else            axi_bus.wready = 1'b1;
      #1;
      // Sample settled DUT outputs
      if (line_done) begin line_done_cnt++; line_done_cyc = cyc; end
      if (word_done) begin word_done_cnt++; word_done_cyc = cyc; end
      if (axi_bus.bready && !axi_bus.bvalid) bwait_cycles++;
      if (axi_bus.awvalid && axi_bus.awready) begin
        aw_addr_q.push_back(axi_bus.awaddr);
        aw_len_q.push_back(axi_bus.awlen);
        aw_cyc_q.push_back(cyc);
        aw_size_seen  = axi_bus.awsize;
        aw_burst_seen = axi_bus.awburst;
        aw_id_seen    = axi_bus.awid;
      end
      if (axi_bus.wvalid) data_cycles++;
      if (held && axi_bus.wdata !== held_wdata) unstable++;
      held       = axi_bus.wvalid && !axi_bus.wready;
      held_wdata = axi_bus.wdata;
      if (axi_bus.wvalid && axi_bus.wready) begin
        w_data_q.push_back(axi_bus.wdata);
        w_strb_q.push_back(axi_bus.wstrb);
        w_last_q.push_back(axi_bus.wlast);
        w_id_seen = axi_bus.wid;
        if (axi_bus.wlast) b_cnt = cfg_bdelay;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    aw_addr_q.delete(); aw_len_q.delete(); aw_cyc_q.delete();
    w_data_q.delete();  w_strb_q.delete(); w_last_q.delete();
    line_done_cnt = 0; word_done_cnt = 0;
    data_cycles = 0; bwait_cycles = 0; unstable = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; line_req = 1'b0; word_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic set_line(input logic [31:0] addr, input logic [31:0] base);
    line_addr = addr;
    for (int i = 0; i < BEATS; i++) line_data[32*i +: 32] = base + 32'(i);
  endtask

  task automatic wait_line(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick(1);
      if (line_done_cnt > 0) begin line_req = 1'b0; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_word(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick(1);
      if (word_done_cnt > 0) begin word_req = 1'b0; ok = 1'b1; break; end
    end
  endtask

  // Counts line beats that differ from base+i; missing beats count too.
  function automatic int bad_beats(input logic [31:0] base);
    int bad = 0;
    for (int i = 0; i < BEATS; i++)
      if (i >= w_data_q.size() || w_data_q[i] !== base + 32'(i)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (axi_bus.awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b exp 0", axi_bus.awvalid); end
    checks++; if (axi_bus.wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b exp 0", axi_bus.wvalid); end
    checks++; if (axi_bus.bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b exp 0", axi_bus.bready); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done: got %b exp 0", line_done); end
    checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL reset_word_done: got %b exp 0", word_done); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single_line();
    int t0; bit ok; int bad_last; int bad_strb;
    clear_logs();
    set_line(32'h1000_0014, 32'h0);
    line_req = 1'b1; t0 = cyc;
    wait_line(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL line_timeout: got no line_done exp one within 40 cycles"); end
    checks++; if (line_done_cyc - t0 !== 11) begin errors++; $display("FAIL line_latency: got %0d exp 11", line_done_cyc - t0); end
    checks++; if (aw_addr_q.size() !== 1 || aw_addr_q[0] !== 32'h1000_0000) begin errors++; $display("FAIL line_awaddr: got %h (n=%0d) exp 10000000", (aw_addr_q.size() > 0) ? aw_addr_q[0] : 32'hx, aw_addr_q.size()); end
    checks++; if (aw_len_q.size() !== 1 || aw_len_q[0] !== 4'd7) begin errors++; $display("FAIL line_awlen: got %0d exp 7", (aw_len_q.size() > 0) ? aw_len_q[0] : 4'hx); end
    checks++; if (aw_size_seen !== 3'b010 || aw_burst_seen !== 2'b01) begin errors++; $display("FAIL line_size_burst: got %b/%b exp 010/01", aw_size_seen, aw_burst_seen); end
    checks++; if (aw_id_seen !== 4'd2 || w_id_seen !== 4'd2) begin errors++; $display("FAIL line_ids: got awid %0d wid %0d exp 2/2", aw_id_seen, w_id_seen); end
    checks++; if (w_data_q.size() !== BEATS || bad_beats(32'h0) != 0) begin errors++; $display("FAIL line_beats: got %0d beats %0d wrong exp 8 beats 0..7", w_data_q.size(), bad_beats(32'h0)); end
    bad_last = 0; bad_strb = 0;
    for (int i = 0; i < w_last_q.size(); i++) begin
      if (w_last_q[i] !== (i == BEATS - 1)) bad_last++;
      if (w_strb_q[i] !== 4'hF) bad_strb++;
    end
    checks++; if (bad_last != 0) begin errors++; $display("FAIL line_wlast: got %0d misplaced wlast exp only beat 7", bad_last); end
    checks++; if (bad_strb != 0) begin errors++; $display("FAIL line_wstrb: got %0d beats not F exp all F", bad_strb); end
    checks++; if (line_done_cnt !== 1) begin errors++; $display("FAIL line_done_count: got %0d exp 1", line_done_cnt); end
  endtask

  task automatic test_single_word();
    int t0; bit ok;
    clear_logs();
    word_addr = 32'hBFD0_0004; word_data = 32'hDEAD_BEEF; word_be = 4'b0011;
    word_req = 1'b1; t0 = cyc;
    wait_word(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL word_timeout: got no word_done exp one within 20 cycles"); end
    checks++; if (word_done_cyc - t0 !== 4) begin errors++; $display("FAIL word_latency: got %0d exp 4", word_done_cyc - t0); end
    checks++; if (aw_addr_q.size() !== 1 || aw_addr_q[0] !== 32'hBFD0_0004 || aw_len_q[0] !== 4'd0) begin errors++; $display("FAIL word_aw: got addr %h len %0d exp bfd00004 len 0", (aw_addr_q.size() > 0) ? aw_addr_q[0] : 32'hx, (aw_len_q.size() > 0) ? aw_len_q[0] : 4'hx); end
    checks++; if (w_data_q.size() !== 1 || w_data_q[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_wdata: got %h (n=%0d) exp deadbeef n=1", (w_data_q.size() > 0) ? w_data_q[0] : 32'hx, w_data_q.size()); end
    checks++; if (w_strb_q.size() !== 1 || w_strb_q[0] !== 4'b0011) begin errors++; $display("FAIL word_wstrb: got %b exp 0011", (w_strb_q.size() > 0) ? w_strb_q[0] : 4'hx); end
    checks++; if (w_last_q.size() !== 1 || w_last_q[0] !== 1'b1) begin errors++; $display("FAIL word_wlast: got %b exp 1 on first beat", (w_last_q.size() > 0) ? w_last_q[0] : 1'b0); end
    checks++; if (line_done_cnt !== 0 || word_done_cnt !== 1) begin errors++; $display("FAIL word_done_count: got line %0d word %0d exp 0/1", line_done_cnt, word_done_cnt); end
  endtask

  task automatic test_word_be_zero();
    bit ok;
    clear_logs();
    word_addr = 32'h0000_0100; word_data = 32'h1234_5678; word_be = 4'b0000;
    word_req = 1'b1;
    wait_word(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL be0_timeout: got no word_done exp one within 20 cycles"); end
    checks++; if (w_data_q.size() !== 1) begin errors++; $display("FAIL be0_beats: got %0d exp 1", w_data_q.size()); end
    checks++; if (w_strb_q.size() !== 1 || w_strb_q[0] !== 4'b0000) begin errors++; $display("FAIL be0_wstrb: got %b exp 0000", (w_strb_q.size() > 0) ? w_strb_q[0] : 4'hx); end
  endtask

  task automatic test_wready_toggle();
    bit ok;
    clear_logs();
    cfg_toggle = 1'b1;
    set_line(32'h5000_0020, 32'hA0);
    line_req = 1'b1;
    wait_line(60, ok);
    cfg_toggle = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL toggle_timeout: got no line_done exp one within 60 cycles"); end
    checks++; if (w_data_q.size() !== BEATS || bad_beats(32'hA0) != 0) begin errors++; $display("FAIL toggle_order: got %0d beats %0d wrong exp 8 beats a0..a7", w_data_q.size(), bad_beats(32'hA0)); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL toggle_stable: got %0d wdata changes while stalled exp 0", unstable); end
    checks++; if (data_cycles !== 16) begin errors++; $display("FAIL toggle_data_cycles: got %0d exp 16", data_cycles); end
  endtask

  task automatic test_bresp_delay();
    int t0; bit ok;
    clear_logs();
    cfg_bdelay = 5; cfg_bresp = 2'b10;
    set_line(32'h6000_0040, 32'h600);
    word_addr = 32'h0000_0200; word_data = 32'h0BAD_F00D; word_be = 4'hF;
    line_req = 1'b1; t0 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick(1);
      if (k == 2) word_req = 1'b1;
      if (line_done_cnt > 0 && line_req) begin line_req = 1'b0; cfg_bdelay = 0; end
      if (word_done_cnt > 0) begin word_req = 1'b0; ok = 1'b1; break; end
    end
    cfg_bresp = 2'b00; cfg_bdelay = 0;
    checks++; if (!ok) begin errors++; $display("FAIL bdelay_timeout: got no word_done exp one within 80 cycles"); end
    checks++; if (line_done_cnt !== 1) begin errors++; $display("FAIL bdelay_done_count: got %0d exp 1", line_done_cnt); end
    checks++; if (line_done_cyc - t0 !== 16) begin errors++; $display("FAIL bdelay_latency: got %0d exp 16", line_done_cyc - t0); end
    checks++; if (bwait_cycles !== 5) begin errors++; $display("FAIL bdelay_bready_held: got %0d waiting cycles exp 5", bwait_cycles); end
    checks++; if (aw_cyc_q.size() !== 2 || aw_cyc_q[1] - line_done_cyc !== 2 || aw_len_q[1] !== 4'd0) begin errors++; $display("FAIL bdelay_next_grant: got %0d aw (gap %0d) exp 2 aw, word aw 2 cycles after done", aw_cyc_q.size(), (aw_cyc_q.size() > 1) ? aw_cyc_q[1] - line_done_cyc : -1); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    clear_logs();
    set_line(32'h2000_0000, 32'h100);
    line_req = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (w_data_q.size() == 3) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_beat3: got %0d beats exp 3", w_data_q.size()); end
    rst_n = 1'b0; line_req = 1'b0;
    #1;
    checks++; if (axi_bus.wvalid !== 1'b0) begin errors++; $display("FAIL rstmid_wvalid: got %b exp 0", axi_bus.wvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    checks++; if (axi_bus.awvalid !== 1'b0 || axi_bus.bready !== 1'b0) begin errors++; $display("FAIL rstmid_aw_b: got awvalid %b bready %b exp 0/0", axi_bus.awvalid, axi_bus.bready); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++; if (line_done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d exp 0", line_done_cnt); end
    clear_logs();
    set_line(32'h2000_0000, 32'h200);
    line_req = 1'b1;
    wait_line(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_retry_timeout: got no line_done exp one within 40 cycles"); end
    checks++; if (w_data_q.size() !== BEATS || bad_beats(32'h200) != 0) begin errors++; $display("FAIL rstmid_retry_beats: got first %h n=%0d exp 200 n=8", (w_data_q.size() > 0) ? w_data_q[0] : 32'hx, w_data_q.size()); end
  endtask

  task automatic test_arbitration();
    int lw; int ll; int pw; int pl;
    logic [3:0] exp_len [4];
    logic [3:0] got;
`ifdef WR_ARBITER_RR_EN
    exp_len = '{4'd0, 4'd7, 4'd0, 4'd7};
`else
    exp_len = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    apply_reset();
    clear_logs();
    set_line(32'h3000_0000, 32'h300);
    word_addr = 32'h4000_0000; word_data = 32'hCAFE_0000; word_be = 4'hF;
    lw = 4; ll = 4; pw = 0; pl = 0;
    line_req = 1'b1; word_req = 1'b1;
    for (int k = 0; k < 300 && (lw > 0 || ll > 0); k++) begin
      tick(1);
      if (word_done_cnt != pw) begin pw = word_done_cnt; lw--; word_req = (lw > 0); end
      if (line_done_cnt != pl) begin pl = line_done_cnt; ll--; line_req = (ll > 0); end
    end
    line_req = 1'b0; word_req = 1'b0;
    checks++; if (lw != 0 || ll != 0) begin errors++; $display("FAIL arb_timeout: got %0d words %0d lines left exp 0/0", lw, ll); end
    checks++; if (aw_len_q.size() !== 8) begin errors++; $display("FAIL arb_count: got %0d grants exp 8", aw_len_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < aw_len_q.size()) ? aw_len_q[i] : 4'hx;
      checks++; if (got !== exp_len[i]) begin errors++; $display("FAIL arb_grant%0d: got awlen %0d exp %0d", i, got, exp_len[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_single_word();
    test_word_be_zero();
    test_wready_toggle();
    test_bresp_delay();
    test_reset_mid_burst();
    test_arbitration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
